// File: rtl/sim_mem_pkg.sv
// Shared types and helpers for the wait-state simulation memory.
// Holds the per-port handshake state encoding and the elaboration-time limits.
package sim_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } port_state_e;

  localparam int MAX_LATENCY = 15;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sim_mem_port.sv
// One handshake port: request capture, wait-state countdown and ack/err pulse.
// The req_* outputs present the request that completes on the current edge.
module sim_mem_port
  import sim_mem_pkg::*;
#(
  parameter int LATENCY    = 0,
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs_i,
  input  logic [31:0]           addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [LANES-1:0]      bytesel_i,
  input  logic                  wr_en_i,
  input  logic                  req_err_i,
  output logic [31:0]           req_addr_o,
  output logic [DATA_WIDTH-1:0] req_wdata_o,
  output logic [LANES-1:0]      req_bytesel_o,
  output logic                  req_wr_en_o,
  output logic                  go_ack_o,
  output logic                  ack_o,
  output logic                  err_o
);

  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  port_state_e           state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [LANES-1:0]      bytesel_q;
  logic                  wr_en_q;
  logic                  ack_q, err_q;
  logic                  capture;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACK: begin
        if (cs_i) begin
          capture = 1'b1;
          cnt_d   = LAT_LOAD;
          state_d = (LATENCY == 0) ? ST_ACK : ST_WAIT;
        end else begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // cs is deliberately ignored while counting down.
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        cnt_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // With zero latency the request completes on its capture edge, so bypass the holding regs.
  assign req_addr_o    = capture ? addr_i    : addr_q;
  assign req_wdata_o   = capture ? wdata_i   : wdata_q;
  assign req_bytesel_o = capture ? bytesel_i : bytesel_q;
  assign req_wr_en_o   = capture ? wr_en_i   : wr_en_q;
  assign go_ack_o      = (state_d == ST_ACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bytesel_q <= '0;
      wr_en_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q    <= addr_i;
        wdata_q   <= wdata_i;
        bytesel_q <= bytesel_i;
        wr_en_q   <= wr_en_i;
      end
      ack_q <= go_ack_o;
      err_q <= go_ack_o & req_err_i;
    end
  end

  assign ack_o = ack_q;
  assign err_o = err_q;

endmodule

// File: rtl/sim_wait_dp_ram.sv
// Dual-port bench memory: instruction read port and data read/write port sharing one array,
// each with its own wait-state latency and out-of-range error response.
module sim_wait_dp_ram
  import sim_mem_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 12,
  parameter int    I_LATENCY  = 0,
  parameter int    D_LATENCY  = 0,
  parameter string INIT_FILE  = "",
  localparam int   LANES      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cs,
  input  logic [31:0]           i_addr,
  output logic [DATA_WIDTH-1:0] i_data,
  output logic                  i_ack,
  output logic                  i_err,
  input  logic                  d_cs,
  input  logic [31:0]           d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [LANES-1:0]      d_bytesel,
  input  logic                  d_wr_en,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  d_err
);

  localparam int OFF    = clog2(LANES);
  localparam int HI_LSB = OFF + ADDR_WIDTH;
  localparam int DEPTH  = 1 << ADDR_WIDTH;

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
    $error("sim_wait_dp_ram: DATA_WIDTH must be 8, 16, 32 or 64");
  end
  if (I_LATENCY < 0 || I_LATENCY > MAX_LATENCY || D_LATENCY < 0 || D_LATENCY > MAX_LATENCY) begin : g_bad_lat
    $error("sim_wait_dp_ram: latency must be 0..15");
  end
  if (HI_LSB > 32) begin : g_bad_addr
    $error("sim_wait_dp_ram: word index does not fit a 32-bit byte address");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [31:0]           i_req_addr, d_req_addr;
  logic [DATA_WIDTH-1:0] i_req_wdata, d_req_wdata;
  logic [LANES-1:0]      i_req_bytesel, d_req_bytesel;
  logic                  i_req_wr_en, d_req_wr_en;
  logic                  i_go, d_go;
  logic                  i_oor, d_oor;
  logic [ADDR_WIDTH-1:0] i_idx, d_idx;

  // Any address bit above the word index field marks the access out of range.
  assign i_oor = (i_req_addr >> HI_LSB) != 32'd0;
  assign d_oor = (d_req_addr >> HI_LSB) != 32'd0;
  assign i_idx = i_req_addr[OFF +: ADDR_WIDTH];
  assign d_idx = d_req_addr[OFF +: ADDR_WIDTH];

  sim_mem_port #(
    .LATENCY    (I_LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_i_port (
    .clk           (clk),
    .rst           (rst),
    .cs_i          (i_cs),
    .addr_i        (i_addr),
    .wdata_i       ('0),
    .bytesel_i     ('0),
    .wr_en_i       (1'b0),
    .req_err_i     (i_oor),
    .req_addr_o    (i_req_addr),
    .req_wdata_o   (i_req_wdata),
    .req_bytesel_o (i_req_bytesel),
    .req_wr_en_o   (i_req_wr_en),
    .go_ack_o      (i_go),
    .ack_o         (i_ack),
    .err_o         (i_err)
  );

  sim_mem_port #(
    .LATENCY    (D_LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_d_port (
    .clk           (clk),
    .rst           (rst),
    .cs_i          (d_cs),
    .addr_i        (d_addr),
    .wdata_i       (d_wdata),
    .bytesel_i     (d_bytesel),
    .wr_en_i       (d_wr_en),
    .req_err_i     (d_oor),
    .req_addr_o    (d_req_addr),
    .req_wdata_o   (d_req_wdata),
    .req_bytesel_o (d_req_bytesel),
    .req_wr_en_o   (d_req_wr_en),
    .go_ack_o      (d_go),
    .ack_o         (d_ack),
    .err_o         (d_err)
  );

  logic unused_i_req;
  assign unused_i_req = &{1'b0, i_req_wdata, i_req_bytesel, i_req_wr_en};

  // rst gates the commit so a write can never land while reset is held.
  always_ff @(posedge clk) begin
    if (d_go && !rst && d_req_wr_en && !d_oor) begin
      for (int b = 0; b < LANES; b++) begin
        if (d_req_bytesel[b]) mem[d_idx][b*8 +: 8] <= d_req_wdata[b*8 +: 8];
      end
    end
  end

  logic [DATA_WIDTH-1:0] i_data_q, d_rdata_q;

  // Non-blocking reads see the pre-write word, giving read-before-write on collisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_data_q  <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_go) i_data_q  <= i_oor ? '0 : mem[i_idx];
      if (d_go) d_rdata_q <= d_oor ? '0 : mem[d_idx];
    end
  end

  assign i_data  = i_data_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_sim_wait_dp_ram.sv
// Randomized bench for sim_wait_dp_ram: two instances (zero-wait and I=2/D=3 wait states)
// compared against a transaction-level word-array model.
module tb_sim_wait_dp_ram;

  logic        clk;
  logic        rst       [2];
  logic        i_cs      [2];
  logic [31:0] i_addr    [2];
  logic [31:0] i_data    [2];
  logic        i_ack     [2];
  logic        i_err     [2];
  logic        d_cs      [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic [3:0]  d_bytesel [2];
  logic        d_wr_en   [2];
  logic [31:0] d_rdata   [2];
  logic        d_ack     [2];
  logic        d_err     [2];

  int i_lat [2];
  int d_lat [2];
  logic [31:0] model [2][64];
  int err_cnt;
  int chk_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sim_wait_dp_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .I_LATENCY(0), .D_LATENCY(0)) dut0 (
    .clk(clk), .rst(rst[0]),
    .i_cs(i_cs[0]), .i_addr(i_addr[0]), .i_data(i_data[0]), .i_ack(i_ack[0]), .i_err(i_err[0]),
    .d_cs(d_cs[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]), .d_bytesel(d_bytesel[0]),
    .d_wr_en(d_wr_en[0]), .d_rdata(d_rdata[0]), .d_ack(d_ack[0]), .d_err(d_err[0])
  );

  sim_wait_dp_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .I_LATENCY(2), .D_LATENCY(3)) dut1 (
    .clk(clk), .rst(rst[1]),
    .i_cs(i_cs[1]), .i_addr(i_addr[1]), .i_data(i_data[1]), .i_ack(i_ack[1]), .i_err(i_err[1]),
    .d_cs(d_cs[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]), .d_bytesel(d_bytesel[1]),
    .d_wr_en(d_wr_en[1]), .d_rdata(d_rdata[1]), .d_ack(d_ack[1]), .d_err(d_err[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit addr_oor(input logic [31:0] a);
    return (a >> 14) != 32'd0;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'd63);
  endfunction

  task automatic d_access(input int u, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] bsel,
                          output logic [31:0] rdata);
    logic [31:0] exp_d;
    bit          exp_e;
    bit          seen;
    int          lat;
    exp_e = addr_oor(addr);
    exp_d = exp_e ? 32'd0 : model[u][widx(addr)];
    seen  = 1'b0;
    lat   = -1;
    rdata = 32'd0;
    @(negedge clk);
    d_cs[u] = 1'b1; d_wr_en[u] = wr; d_addr[u] = addr; d_wdata[u] = wdata; d_bytesel[u] = bsel;
    @(posedge clk);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (d_ack[u]) begin
        seen  = 1'b1;
        lat   = k;
        rdata = d_rdata[u];
      end
      if (k == 0) d_cs[u] = 1'b0;
    end
    if (!seen) begin
      check("d_ack_timeout", 32'd0, 32'd1);
    end else begin
      check("d_latency", lat, d_lat[u]);
      check("d_rdata", rdata, exp_d);
      check("d_err", {31'd0, d_err[u]}, {31'd0, exp_e});
      @(negedge clk);
      check("d_ack_pulse", {31'd0, d_ack[u]}, 32'd0);
    end
    if (wr && !exp_e) begin
      for (int b = 0; b < 4; b++)
        if (bsel[b]) model[u][widx(addr)][b*8 +: 8] = wdata[b*8 +: 8];
    end
    $display("dut%0d D %s addr=%h wdata=%h bsel=%b rdata=%h lat=%0d", u, wr ? "WR" : "RD",
             addr, wdata, bsel, rdata, lat);
  endtask

  task automatic i_access(input int u, input logic [31:0] addr, output logic [31:0] rdata);
    logic [31:0] exp_d;
    bit          exp_e;
    bit          seen;
    int          lat;
    exp_e = addr_oor(addr);
    exp_d = exp_e ? 32'd0 : model[u][widx(addr)];
    seen  = 1'b0;
    lat   = -1;
    rdata = 32'd0;
    @(negedge clk);
    i_cs[u] = 1'b1; i_addr[u] = addr;
    @(posedge clk);
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (i_ack[u]) begin
        seen  = 1'b1;
        lat   = k;
        rdata = i_data[u];
      end
      if (k == 0) i_cs[u] = 1'b0;
    end
    if (!seen) begin
      check("i_ack_timeout", 32'd0, 32'd1);
    end else begin
      check("i_latency", lat, i_lat[u]);
      check("i_data", rdata, exp_d);
      check("i_err", {31'd0, i_err[u]}, {31'd0, exp_e});
      @(negedge clk);
      check("i_ack_pulse", {31'd0, i_ack[u]}, 32'd0);
    end
    $display("dut%0d I RD addr=%h rdata=%h lat=%0d", u, addr, rdata, lat);
  endtask

  task automatic check_outputs_zero(input int u, input string tag);
    check({tag, "_i_ack"}, {31'd0, i_ack[u]}, 32'd0);
    check({tag, "_i_err"}, {31'd0, i_err[u]}, 32'd0);
    check({tag, "_i_data"}, i_data[u], 32'd0);
    check({tag, "_d_ack"}, {31'd0, d_ack[u]}, 32'd0);
    check({tag, "_d_err"}, {31'd0, d_err[u]}, 32'd0);
    check({tag, "_d_rdata"}, d_rdata[u], 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    int          exp_ack [5];
    err_cnt = 0;
    chk_cnt = 0;
    i_lat[0] = 0; i_lat[1] = 2;
    d_lat[0] = 0; d_lat[1] = 3;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; i_cs[u] = 1'b0; i_addr[u] = '0; d_cs[u] = 1'b0; d_addr[u] = '0;
      d_wdata[u] = '0; d_bytesel[u] = '0; d_wr_en[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_outputs_zero(0, "rst0");
    check_outputs_zero(1, "rst1");
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // Fill the modelled region so every later read has a known value.
    for (int u = 0; u < 2; u++)
      for (int w = 0; w < 64; w++)
        d_access(u, 1'b1, 32'(w * 4), $urandom, 4'hF, r);

    // Byte lanes.
    d_access(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, r);
    d_access(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, r);
    d_access(0, 1'b0, 32'h10, 32'h0, 4'b0000, r);
    check("lanes_word", r, 32'hDEADBEAA);
    d_access(0, 1'b1, 32'h14, 32'h12345678, 4'b0000, r);
    d_access(0, 1'b0, 32'h14, 32'h0, 4'b0000, r);

    // Back-to-back fetches with cs held high.
    @(negedge clk);
    i_cs[0] = 1'b1; i_addr[0] = 32'h0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("b2b_ack", {31'd0, i_ack[0]}, 32'd1);
      check("b2b_data", i_data[0], model[0][j]);
      if (j < 3) i_addr[0] = 32'((j + 1) * 4);
      else i_cs[0] = 1'b0;
    end
    @(negedge clk);
    check("b2b_end", {31'd0, i_ack[0]}, 32'd0);
    $display("dut0 I back-to-back words 0..3");

    // Same-edge collision: fetch sees the old word.
    d_access(0, 1'b1, 32'h20, 32'h11111111, 4'hF, r);
    @(negedge clk);
    d_cs[0] = 1'b1; d_wr_en[0] = 1'b1; d_addr[0] = 32'h20; d_wdata[0] = 32'h22222222; d_bytesel[0] = 4'hF;
    i_cs[0] = 1'b1; i_addr[0] = 32'h20;
    @(negedge clk);
    d_cs[0] = 1'b0; i_cs[0] = 1'b0;
    check("coll_i_ack", {31'd0, i_ack[0]}, 32'd1);
    check("coll_i_old", i_data[0], 32'h11111111);
    check("coll_d_ack", {31'd0, d_ack[0]}, 32'd1);
    check("coll_d_prewrite", d_rdata[0], 32'h11111111);
    model[0][8] = 32'h22222222;
    $display("dut0 collision write/read addr=00000020");
    i_access(0, 32'h20, r);
    check("coll_i_new", r, 32'h22222222);

    // Out-of-range write must not alias onto word 0.
    d_access(0, 1'b1, 32'h4000, 32'hCAFEF00D, 4'hF, r);
    d_access(0, 1'b0, 32'h0000, 32'h0, 4'h0, r);
    i_access(0, 32'h4000, r);

    // Wait states on dut1: cs during WAIT ignored.
    exp_ack = '{0, 0, 1, 0, 0};
    @(negedge clk);
    i_cs[1] = 1'b1; i_addr[1] = 32'h8;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("wait_ack", {31'd0, i_ack[1]}, exp_ack[j]);
      if (j == 2) check("wait_data", i_data[1], model[1][2]);
      if (j == 1) i_cs[1] = 1'b0;
    end
    $display("dut1 I wait-state fetch addr=00000008");

    // Reset while a write sits in WAIT: write dropped, no ack.
    @(negedge clk);
    d_cs[1] = 1'b1; d_wr_en[1] = 1'b1; d_addr[1] = 32'h14; d_wdata[1] = ~model[1][5]; d_bytesel[1] = 4'hF;
    @(negedge clk);
    d_cs[1] = 1'b0;
    check("rstwait_ack0", {31'd0, d_ack[1]}, 32'd0);
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    check_outputs_zero(1, "rstwait");
    @(negedge clk);
    rst[1] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("rstwait_noack", {31'd0, d_ack[1]}, 32'd0);
    end
    $display("dut1 D write aborted by reset addr=00000014");
    d_access(1, 1'b0, 32'h14, 32'h0, 4'h0, r);

    // Randomized mix on both instances.
    for (int n = 0; n < 300; n++) begin
      int u;
      int op;
      u  = n % 2;
      op = $urandom_range(0, 2);
      a  = 32'(($urandom_range(0, 63) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 255) << 14);
      case (op)
        0: d_access(u, 1'b1, a, $urandom, 4'($urandom_range(0, 15)), r);
        1: d_access(u, 1'b0, a, 32'h0, 4'h0, r);
        default: i_access(u, a, r);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
